// File: rtl/embedded_system_st_to_mem_writer_if.sv
// Bus bundle for the stream-to-memory writer: CSR slave port, Avalon-ST sink and
// Avalon-MM write master. The slave modport is the writer's view of the bundle.
interface embedded_system_st_to_mem_writer_if #(
    parameter int ADDR_W = 15
);
    logic [1:0]        csr_address;
    logic              csr_chipselect;
    logic              csr_write;
    logic              csr_read;
    logic [31:0]       csr_writedata;
    logic [31:0]       csr_readdata;

    logic [7:0]        snk_data;
    logic              snk_valid;
    logic              snk_endofpacket;
    logic              snk_ready;

    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_writedata;
    logic              mem_chipselect;
    logic              mem_write;

    modport slave (
        input  csr_address, csr_chipselect, csr_write, csr_read, csr_writedata,
        output csr_readdata,
        input  snk_data, snk_valid, snk_endofpacket,
        output snk_ready,
        output mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write
    );

    modport master (
        output csr_address, csr_chipselect, csr_write, csr_read, csr_writedata,
        input  csr_readdata,
        output snk_data, snk_valid, snk_endofpacket,
        input  snk_ready,
        input  mem_address, mem_byteenable, mem_writedata, mem_chipselect, mem_write
    );
endinterface

// File: rtl/embedded_system_st_to_mem_writer.sv
// Packs an Avalon-ST byte stream little-endian into 32-bit words and writes them to
// consecutive word addresses; software programs base/limit and starts each transfer.
module embedded_system_st_to_mem_writer #(
    parameter int ADDR_W = 15
) (
    input  logic                                clk,
    input  logic                                reset,
    embedded_system_st_to_mem_writer_if.slave   bus,
    output logic                                irq
);
    typedef enum logic [1:0] {S_IDLE, S_PACK, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   limit_q, limit_d;
    logic [ADDR_W-1:0] word_ptr_q, word_ptr_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       bytecount_q, bytecount_d;
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              csr_wr, csr_rd, busy, go, snk_ready_c, accept, word_last;
    logic [31:0]       word_fill;
    logic [3:0]        lane_be;
    logic [ADDR_W:0]   words_inc;
    logic              unused_wdata;

    assign csr_wr      = bus.csr_chipselect & bus.csr_write;
    assign csr_rd      = bus.csr_chipselect & bus.csr_read;
    assign busy        = (state_q != S_IDLE);
    assign go          = csr_wr && (bus.csr_address == 2'd2) && bus.csr_writedata[0] && !busy;
    assign snk_ready_c = (state_q == S_PACK) && (words_q < limit_q);
    assign accept      = bus.snk_valid & snk_ready_c;
    assign word_last   = accept && ((lane_q == 2'd3) || bus.snk_endofpacket);
    assign word_fill   = shift_q | ({24'b0, bus.snk_data} << {lane_q, 3'b000});
    assign words_inc   = words_q + (ADDR_W+1)'(1);
    assign unused_wdata = ^bus.csr_writedata[31:ADDR_W+1];

    always_comb begin
        case (lane_q)
            2'd0:    lane_be = 4'b0001;
            2'd1:    lane_be = 4'b0011;
            2'd2:    lane_be = 4'b0111;
            default: lane_be = 4'b1111;
        endcase
    end

    // NOTE: every next-state variable takes its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        limit_d     = limit_q;
        word_ptr_d  = word_ptr_q;
        words_d     = words_q;
        lane_d      = lane_q;
        shift_d     = shift_q;
        bytecount_d = bytecount_q;
        irq_en_d    = irq_en_q;
        done_d      = done_q;
        ovf_d       = ovf_q;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;

        // Software side first, so a status set by the FSM below overrides a same-cycle clear.
        if (csr_wr) begin
            case (bus.csr_address)
                2'd0: if (!busy) base_d  = bus.csr_writedata[ADDR_W-1:0];
                2'd1: if (!busy) limit_d = bus.csr_writedata[ADDR_W:0];
                2'd2: begin
                    irq_en_d = bus.csr_writedata[1];
                    if (bus.csr_writedata[1]) begin
                        done_d = 1'b0;
                        ovf_d  = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (csr_rd) begin
            case (bus.csr_address)
                2'd0:    rdata_d = 32'(base_q);
                2'd1:    rdata_d = 32'(limit_q);
                2'd2:    rdata_d = {28'b0, irq_en_q, ovf_q, done_q, busy};
                default: rdata_d = bytecount_q;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    word_ptr_d  = base_q;
                    words_d     = '0;
                    lane_d      = 2'd0;
                    shift_d     = '0;
                    bytecount_d = '0;
                    done_d      = 1'b0;
                    ovf_d       = 1'b0;
                    state_d     = S_PACK;
                end
            end
            S_PACK: begin
                if (accept) begin
                    bytecount_d = bytecount_q + 32'd1;
                    if (word_last) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = word_ptr_q;
                        mem_be_d    = lane_be;
                        mem_wdata_d = word_fill;
                        word_ptr_d  = word_ptr_q + ADDR_W'(1);
                        words_d     = words_inc;
                        lane_d      = 2'd0;
                        shift_d     = '0;
                        if (bus.snk_endofpacket) begin
                            state_d = S_DONE;
                        end else if (words_inc == limit_q) begin
                            ovf_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    end else begin
                        lane_d  = lane_q + 2'd1;
                        shift_d = word_fill;
                    end
                end else if (words_q >= limit_q) begin
                    // Reached only with LIMIT=0: nothing may be accepted at all.
                    ovf_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            limit_q     <= '0;
            word_ptr_q  <= '0;
            words_q     <= '0;
            lane_q      <= '0;
            shift_q     <= '0;
            bytecount_q <= '0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            limit_q     <= limit_d;
            word_ptr_q  <= word_ptr_d;
            words_q     <= words_d;
            lane_q      <= lane_d;
            shift_q     <= shift_d;
            bytecount_q <= bytecount_d;
            irq_en_q    <= irq_en_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.snk_ready      = snk_ready_c;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_chipselect = mem_write_q;
    assign bus.mem_address    = mem_addr_q;
    assign bus.mem_byteenable = mem_be_q;
    assign bus.mem_writedata  = mem_wdata_q;
    assign bus.csr_readdata   = rdata_q;
    assign irq                = done_q & irq_en_q;
endmodule

// File: tb/tb_embedded_system_st_to_mem_writer.sv
// Table-driven bench for the stream-to-memory writer: a packing model fills a write
// scoreboard that a bus monitor drains, plus hand sequences for irq and mid-packet reset.
module tb_embedded_system_st_to_mem_writer;
    localparam int ADDR_W = 15;

    logic clk = 1'b0;
    logic reset;
    logic irq;
    always #5 clk = ~clk;

    embedded_system_st_to_mem_writer_if #(.ADDR_W(ADDR_W)) bus ();

    embedded_system_st_to_mem_writer #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;
    int wr_seen = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       data;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   limit;
        logic [7:0]        first;
        int                n;
        bit                eop;
        bit                irq_en;
        int                exp_acc;
        bit                exp_ovf;
        int                exp_words;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Memory-side monitor: every presented write must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (bus.mem_write) begin
            wr_seen++;
            if (sb.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL unexpected_write: addr 0x%04h data 0x%08h, no write expected",
                         bus.mem_address, bus.mem_writedata);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(bus.mem_address), 32'(e.addr));
                check("wr_be", 32'(bus.mem_byteenable), 32'(e.be));
                check("wr_data", bus.mem_writedata & be_mask(e.be), e.data & be_mask(e.be));
                check("wr_cs", 32'(bus.mem_chipselect), 32'd1);
            end
        end
    end

    // Reference packer: pushes the writes a transfer of n bytes (first, first+1, ...) should produce.
    task automatic model(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] limit,
                         input logic [7:0] first, input int n, input bit eop);
        logic [31:0]       w = '0;
        logic [ADDR_W-1:0] ptr = base;
        int                lane = 0;
        int                words = 0;
        for (int i = 0; i < n; i++) begin
            if (words >= int'(limit)) break;
            w[lane*8 +: 8] = first + 8'(i);
            if (lane == 3 || (eop && i == n - 1)) begin
                sb.push_back('{ptr, 4'((1 << (lane + 1)) - 1), w});
                ptr   = ptr + 1'b1;
                words++;
                lane  = 0;
                w     = '0;
            end else begin
                lane++;
            end
        end
    endtask

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        bus.csr_address    = a;
        bus.csr_writedata  = d;
        bus.csr_chipselect = 1'b1;
        bus.csr_write      = 1'b1;
        @(posedge clk); #1;
        bus.csr_chipselect = 1'b0;
        bus.csr_write      = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
        bus.csr_address    = a;
        bus.csr_chipselect = 1'b1;
        bus.csr_read       = 1'b1;
        @(posedge clk); #1;
        bus.csr_chipselect = 1'b0;
        bus.csr_read       = 1'b0;
        d = bus.csr_readdata;
    endtask

    // Sends up to n bytes; gives up on a byte after 8 stalled cycles and reports how many went in.
    task automatic stream(input logic [7:0] first, input int n, input bit eop, output int acc);
        int idle;
        bit rdy;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            bus.snk_valid       = 1'b1;
            bus.snk_data        = first + 8'(i);
            bus.snk_endofpacket = eop && (i == n - 1);
            idle = 0;
            do begin
                @(negedge clk);
                rdy = bus.snk_ready;
                if (!rdy) idle++;
                @(posedge clk); #1;
            end while (!rdy && idle < 8);
            if (!rdy) break;
            acc++;
        end
        bus.snk_valid       = 1'b0;
        bus.snk_endofpacket = 1'b0;
    endtask

    task automatic wait_idle(output logic [31:0] st);
        for (int k = 0; k < 20; k++) begin
            csr_rd(2'd2, st);
            if (!st[0]) return;
        end
        check("busy_timeout", 32'(st[0]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] st;
        int          acc;
        int          wr_before;

        vecs[0] = '{15'h0100, 16'd4, 8'h11, 8,  1'b1, 1'b0, 8,  1'b0, 2};
        vecs[1] = '{15'h0100, 16'd4, 8'hA0, 6,  1'b1, 1'b1, 6,  1'b0, 2};
        vecs[2] = '{15'h0200, 16'd2, 8'h30, 12, 1'b0, 1'b0, 8,  1'b1, 2};
        vecs[3] = '{15'h7FFF, 16'd2, 8'h50, 8,  1'b1, 1'b0, 8,  1'b0, 2};
        vecs[4] = '{15'h0010, 16'd0, 8'h99, 1,  1'b1, 1'b0, 0,  1'b1, 0};
        vecs[5] = '{15'h0300, 16'd8, 8'hC5, 1,  1'b1, 1'b0, 1,  1'b0, 1};
        vecs[6] = '{15'h0400, 16'd3, 8'h60, 12, 1'b1, 1'b1, 12, 1'b0, 3};

        bus.csr_address     = '0;
        bus.csr_chipselect  = 1'b0;
        bus.csr_write       = 1'b0;
        bus.csr_read        = 1'b0;
        bus.csr_writedata   = '0;
        bus.snk_data        = '0;
        bus.snk_valid       = 1'b0;
        bus.snk_endofpacket = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_snk_ready", 32'(bus.snk_ready), 32'd0);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_mem_cs", 32'(bus.mem_chipselect), 32'd0);
        check("rst_mem_be", 32'(bus.mem_byteenable), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_address), 32'd0);
        check("rst_mem_wdata", bus.mem_writedata, 32'd0);
        check("rst_readdata", bus.csr_readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(posedge clk); #1;
        for (int a = 0; a < 4; a++) begin
            csr_rd(2'(a), r);
            check($sformatf("rst_csr%0d", a), r, 32'd0);
        end

        foreach (vecs[v]) begin
            wr_before = wr_seen;
            csr_wr(2'd0, 32'(vecs[v].base));
            csr_wr(2'd1, 32'(vecs[v].limit));
            csr_rd(2'd1, r);
            check($sformatf("v%0d_limit_rd", v), r, 32'(vecs[v].limit));
            model(vecs[v].base, vecs[v].limit, vecs[v].first, vecs[v].n, vecs[v].eop);
            csr_wr(2'd2, {30'b0, vecs[v].irq_en, 1'b1});
            @(negedge clk);
            check($sformatf("v%0d_ready_after_go", v), 32'(bus.snk_ready), 32'(vecs[v].limit != 0));
            @(posedge clk); #1;
            stream(vecs[v].first, vecs[v].n, vecs[v].eop, acc);
            check($sformatf("v%0d_accepted", v), 32'(acc), 32'(vecs[v].exp_acc));
            if (vecs[v].exp_ovf) begin
                @(negedge clk);
                check($sformatf("v%0d_stalled", v), 32'(bus.snk_ready), 32'd0);
                @(posedge clk); #1;
            end
            wait_idle(st);
            check($sformatf("v%0d_done", v), 32'(st[1]), 32'd1);
            check($sformatf("v%0d_ovf", v), 32'(st[2]), 32'(vecs[v].exp_ovf));
            csr_rd(2'd3, r);
            check($sformatf("v%0d_bytecount", v), r, 32'(vecs[v].exp_acc));
            check($sformatf("v%0d_nwrites", v), 32'(wr_seen - wr_before), 32'(vecs[v].exp_words));
            check($sformatf("v%0d_sb_empty", v), 32'(sb.size()), 32'd0);
            @(negedge clk);
            check($sformatf("v%0d_irq", v), 32'(irq), 32'(vecs[v].irq_en));
            @(posedge clk); #1;
        end

        // Software acknowledge: writing 0x2 keeps irq_en but clears done, dropping irq.
        csr_wr(2'd2, 32'h2);
        @(negedge clk);
        check("ack_irq", 32'(irq), 32'd0);
        @(posedge clk); #1;
        csr_rd(2'd2, st);
        check("ack_status", st, 32'h8);
        repeat (2) @(posedge clk);
        #1;
        check("readdata_hold", bus.csr_readdata, st);

        // Mid-packet reset: three bytes sit in the packer, then reset discards them.
        wr_before = wr_seen;
        csr_wr(2'd0, 32'h40);
        csr_wr(2'd1, 32'd4);
        csr_wr(2'd2, 32'h1);
        stream(8'h70, 3, 1'b0, acc);
        check("mid_accepted", 32'(acc), 32'd3);
        csr_wr(2'd0, 32'h1234);
        csr_rd(2'd0, r);
        check("busy_base_locked", r, 32'h40);
        csr_wr(2'd2, 32'h1);
        csr_rd(2'd3, r);
        check("busy_go_ignored", r, 32'd3);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_ready", 32'(bus.snk_ready), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        @(posedge clk); #1;
        for (int a = 0; a < 4; a++) begin
            csr_rd(2'(a), r);
            check($sformatf("mid_rst_csr%0d", a), r, 32'd0);
        end
        check("mid_rst_nwrites", 32'(wr_seen - wr_before), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/embedded_system_st_to_mem_writer.md
# embedded_system_st_to_mem_writer

Avalon-ST to Avalon-MM write master that sits directly upstream of the 32-bit on-chip memory slave. It accepts a byte stream, packs bytes little-endian into 32-bit words, and writes them to consecutive word addresses with per-lane byteenables. A small CSR slave lets the Nios software program the base address and word limit, start a transfer, and see completion, overflow and the byte count; an optional interrupt signals the end of each transfer.

## Interface
- ADDR_W, 15, word-address width of the memory port
- clk  in  1  single clock domain
- reset  in  1  synchronous, active-high
- csr_address  in  2  0=BASE, 1=LIMIT, 2=CONTROL/STATUS, 3=BYTECOUNT
- csr_chipselect, csr_write, csr_read  in  1 each  CSR slave strobes
- csr_writedata  in  32  CSR write data
- csr_readdata  out  32  CSR read data, registered, valid 1 cycle after csr_read
- snk_data  in  8  stream byte
- snk_valid  in  1  byte valid
- snk_endofpacket  in  1  last byte of packet
- snk_ready  out  1  sink ready; a byte transfers when snk_valid & snk_ready
- mem_address  out  ADDR_W  word address to memory
- mem_byteenable  out  4  lane enables
- mem_writedata  out  32  packed word
- mem_chipselect, mem_write  out  1 each  write strobe; both asserted together for exactly one cycle per word
- irq  out  1  level interrupt = done & irq_en

## Operation
- Registers: BASE[ADDR_W-1:0] (word address); LIMIT[ADDR_W:0] (max words; 0 means no words, so a go finishes immediately with overflow=1); CONTROL bit0 go (write-only pulse), bit1 irq_en; STATUS on read of address 2: bit0 busy, bit1 done, bit2 overflow, bit3 irq_en. Writing 1 to bit1 of address 2 clears done and overflow. BYTECOUNT is read-only and holds the bytes accepted in the current or last transfer.
- FSM states: IDLE, PACK, DONE.
- IDLE: snk_ready=0. On a write to CONTROL with bit0=1: load word_ptr=BASE, words=0, lane=0, BYTECOUNT=0, clear done/overflow, and go to PACK.
- PACK: snk_ready=1 while words<LIMIT. Each accepted byte goes into lane `lane` of the shift word, lane increments, and BYTECOUNT increments.
  - When lane reaches 4 or EOP is accepted, issue a write with byteenable set for the filled lanes (EOP with 1 byte gives 0001, 2 gives 0011, 3 gives 0111, 4 gives 1111). Then word_ptr++ (modulo 2^ADDR_W), words++, lane=0.
  - EOP goes to DONE.
  - Once words==LIMIT with no EOP yet: snk_ready=0, overflow=1, go to DONE. Unaccepted stream bytes stay stalled upstream.
- DONE: set done for one cycle of state and return to IDLE. done stays set until cleared by software.
- go while busy is ignored. CSR writes to BASE/LIMIT while busy are ignored.
- If the clear of done and a new done setting happen in the same cycle, the set wins.
- Reset mid-transfer discards the partial word, issues no further write, and returns to IDLE. Memory contents are not touched.
- The memory slave has no waitrequest, so every issued write completes in one cycle.

## Timing
- Reset values: snk_ready=0, mem_write=0, mem_chipselect=0, mem_byteenable=0, mem_address=0, mem_writedata=0, csr_readdata=0, irq=0. BASE=0, LIMIT=0, irq_en=0, done=0, overflow=0, BYTECOUNT=0, state IDLE.
- snk_ready rises the cycle after the go write.
- A write strobe is registered. The word completed by the byte accepted at edge N is presented during cycle N+1 and captured by memory at edge N+1.
- Sustained throughput is 1 byte/cycle, giving mem_write every 4th cycle. There are no bubbles between packets beyond the CSR go.
- busy drops and done/irq assert the cycle after the final write is presented.
- csr_readdata updates at the edge after csr_read & csr_chipselect and holds its value otherwise.

## Test plan
- BASE=0x0100, LIMIT=4, go, stream bytes 0x11..0x18 continuously with EOP on 0x18 -> writes 0x14131211 to 0x0100 and 0x18171615 to 0x0101, both be=1111. Then done=1, overflow=0, BYTECOUNT=8.
- Stream of 6 bytes 0xA0..0xA5 with EOP on the last byte -> writes 0xA3A2A1A0 (be=1111) and 0x????A5A4 (be=0011) to 0x0101. BYTECOUNT=6.
- LIMIT=2, 12-byte stream without EOP -> exactly 2 writes, snk_ready=0 after byte 8, overflow=1, done=1, bytes 9..12 remain stalled.
- irq_en=1 with a completed transfer -> irq=1; write 0x2 to address 2 -> irq=0, done=0 on the next read.
- Assert reset after 3 bytes of a packet -> no write issued, snk_ready=0, and all status and count reads return 0.
- BASE=0x7FFF, LIMIT=2, 8 bytes -> writes to 0x7FFF then 0x0000, the address wrapping modulo 2^15.
